// File: rtl/lsu_pkg.sv
// Shared encodings for the byte-serial load/store initiator.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_e;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_BYTE: n = 3'd1;
            SIZE_HALF: n = 3'd2;
            SIZE_WORD: n = 3'd4;
            default:   n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_byte_master_load_extend.sv
// Sign/zero extension of an assembled little-endian load value.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ext
);

    logic fill_byte_s;
    logic fill_half_s;

    assign fill_byte_s = ~is_unsigned & data[7];
    assign fill_half_s = ~is_unsigned & data[15];

    // Select the extension width from the access size.
    always_comb begin
        ext = 32'd0;
        case (size)
            SIZE_BYTE: ext = {{24{fill_byte_s}}, data[7:0]};
            SIZE_HALF: ext = {{16{fill_half_s}}, data[15:0]};
            SIZE_WORD: ext = data;
            default:   ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_byte_master.sv
// Splits byte/half/word core requests into byte transactions and reassembles loads.
module lsu_byte_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    lsu_state_e        state_r;
    logic              store_r;
    logic [1:0]        size_r;
    logic              unsigned_r;
    logic [31:0]       wdata_r;
    logic [2:0]        idx_r;
    logic [2:0]        last_idx_r;
    logic [31:0]       asm_r;
    logic [31:0]       asm_next_s;
    logic [31:0]       ext_s;
    logic [2:0]        req_last_s;

    logic              req_ready_r;
    logic              resp_valid_r;
    logic [31:0]       resp_rdata_r;
    logic              resp_err_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        mem_wdata_r;

    assign req_last_s = byte_count(req_size) - 3'd1;

    // Drop the incoming read byte into its lane of the assembly word.
    always_comb begin
        asm_next_s = asm_r;
        case (idx_r)
            3'd0:    asm_next_s[7:0]   = mem_rdata;
            3'd1:    asm_next_s[15:8]  = mem_rdata;
            3'd2:    asm_next_s[23:16] = mem_rdata;
            3'd3:    asm_next_s[31:24] = mem_rdata;
            default: asm_next_s = asm_r;
        endcase
    end

    // Extension sees the word including the final byte so the response can be registered.
    load_extend u_load_extend (
        .data        (asm_next_s),
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .ext         (ext_s)
    );

    // Request sequencing; every output is a register updated with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            store_r      <= 1'b0;
            size_r       <= SIZE_BYTE;
            unsigned_r   <= 1'b0;
            wdata_r      <= 32'd0;
            idx_r        <= 3'd0;
            last_idx_r   <= 3'd0;
            asm_r        <= 32'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        store_r     <= req_store;
                        size_r      <= req_size;
                        unsigned_r  <= req_unsigned;
                        req_ready_r <= 1'b0;
                        if (req_size == SIZE_ILL) begin
                            state_r      <= DONE;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'd0;
                        end else begin
                            state_r     <= ACCESS;
                            idx_r       <= 3'd0;
                            last_idx_r  <= req_last_s;
                            asm_r       <= 32'd0;
                            wdata_r     <= {8'd0, req_wdata[31:8]};
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= req_store;
                            mem_addr_r  <= req_addr;
                            mem_wdata_r <= req_wdata[7:0];
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        asm_r <= asm_next_s;
                        if (idx_r == last_idx_r) begin
                            state_r      <= DONE;
                            mem_req_r    <= 1'b0;
                            mem_we_r     <= 1'b0;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b0;
                            resp_rdata_r <= store_r ? 32'd0 : ext_s;
                        end else begin
                            idx_r       <= idx_r + 3'd1;
                            mem_addr_r  <= mem_addr_r + ADDR_W'(1);
                            mem_wdata_r <= wdata_r[7:0];
                            wdata_r     <= {8'd0, wdata_r[31:8]};
                        end
                    end else begin
                        mem_req_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'd0;
                    resp_err_r   <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'd0;
                    resp_err_r   <= 1'b0;
                    mem_req_r    <= 1'b0;
                    mem_we_r     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: doc/lsu_byte_master.md
# lsu_byte_master

Multi-cycle load/store initiator between the core's memory stage and a byte-wide data-memory port. It accepts one byte, half or word request, splits it into little-endian byte transactions on a valid/ack memory handshake, and reassembles load data with sign or zero extension. It is the requesting end of the byte-addressed data-memory interface and handles misaligned accesses byte by byte.

## Interface

- ADDR_W, 32, address width for core and memory sides.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  core request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_store  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: zero-extend (lbu/lhu) instead of sign-extend.
- req_addr  input  ADDR_W  byte address of the lowest byte.
- req_wdata  input  32  store data, byte 0 in bits [7:0].
- resp_valid  output  1  one-cycle pulse: request complete.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid; 1 for illegal size.
- mem_req  output  1  byte transaction request.
- mem_we  output  1  1 = byte write.
- mem_addr  output  ADDR_W  byte address.
- mem_wdata  output  8  write byte.
- mem_ack  input  1  transaction accepted/completed this cycle.
- mem_rdata  input  8  read byte, valid when mem_ack is high.

## Operation

- States: IDLE, ACCESS, DONE.
- IDLE: req_ready=1. On req_valid&req_ready: latch store, size, unsigned, addr, wdata. Set byte count N = 1/2/4 and index i=0. Go to ACCESS; for size 11, go straight to DONE with err set.
- ACCESS: mem_req=1, mem_addr = latched addr + i (modulo 2^ADDR_W, so wrap past all-ones is legal). mem_we=store. mem_wdata = wdata byte i. Outputs stay stable until mem_ack is sampled high.
  - On ack: a load writes mem_rdata into byte lane i of the assembly register. If i==N-1, go to DONE; otherwise i++.
- DONE: resp_valid=1 for exactly one cycle, then return to IDLE. No back-pressure on the response.
  - Load: resp_rdata = lanes 0..N-1; upper bits are filled with bit 7 of lane N-1 if signed, else with 0.
  - Store or error: resp_rdata=0.
- mem_ack outside ACCESS is ignored. mem_req is never high outside ACCESS.
- No alignment requirement: a half at 0x...FFF touches 0x...FFF then 0x...1000.

## Timing

- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Request accepted at edge T. mem_req is high from cycle T+1.
- With mem_ack tied high, byte k is issued in cycle T+1+k. resp_valid is high in cycle T+N+1, and req_ready returns in cycle T+N+2. Turnaround is N+2 cycles; an illegal request takes 2 cycles.
- Each cycle mem_ack is low adds one cycle of latency; address and data hold.
- An ack arriving in the same cycle as mem_req rises counts; a combinational responder is supported.
- Reset assertion mid-ACCESS: mem_req drops immediately (asynchronous), no response is produced, and the partial store bytes already acknowledged remain in memory.
- All outputs are registered or decoded from registered state only. There are no combinational paths from req_* to mem_*.

## Structure

- Package lsu_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILL encodings.
  - State enum {IDLE, ACCESS, DONE}.
  - A function returning byte count from size.
- One sub-module, load_extend: combinational; inputs are the assembled 32-bit value, size and unsigned; output is the extended word. Used in DONE.

## Test plan

- Word store 0xDEADBEEF at 0x100, ack tied high -> mem writes at 0x100..0x103 in consecutive cycles with bytes EF,BE,AD,DE. resp_valid arrives 5 cycles after acceptance, rdata=0, err=0.
- Signed byte load at 0x20 returning 0x80 -> resp_rdata=0xFFFFFF80. The same access with req_unsigned=1 -> 0x00000080.
- Half load at 0xFFFFFFFF (wrap) returning 0x34 then 0x12 -> addresses 0xFFFFFFFF then 0x00000000, resp_rdata=0x00001234.
- Word load with ack low 2 cycles on byte 1 -> mem_addr/mem_req held stable during the stall, resp_valid delayed by exactly 2 cycles, data correct.
- req_size=11 -> no mem_req ever. resp_valid appears 1 cycle after acceptance with err=1 and rdata=0.
- rst_n pulsed low during byte 2 of a word store -> mem_req low in the same cycle, no resp_valid, req_ready=1 after release, and the next request behaves normally.
